ov7670_stream_gen: RTL and testbench



---
 rtl/ov7670_stream_gen.sv | 168 ++++++++++++++++
 tb/tb_ov7670_stream_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_stream_gen.sv
// OV7670-style camera stream generator: emits PCLK/VSYNC/HREF/D in RGB444
// (two bytes per pixel) with selectable test patterns, pclk = clk/2.
module ov7670_stream_gen #(
  parameter int unsigned IMG_WIDTH   = 640,
  parameter int unsigned IMG_HEIGHT  = 480,
  parameter int unsigned H_BLANK     = 288,
  parameter int unsigned VSYNC_LINES = 3,
  parameter int unsigned V_BACK      = 17,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned STRIPE_H    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  pattern,
  input  logic [11:0] solid_rgb,
  output logic        pclk,
  output logic        vsync,
  output logic        href,
  output logic [7:0]  d,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        busy
);

  localparam int unsigned ACT_BYTES  = 2 * IMG_WIDTH;
  localparam int unsigned LINE_BYTES = ACT_BYTES + H_BLANK;
  localparam int unsigned BAR_W      = IMG_WIDTH / 8;
  localparam int unsigned BW         = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
  localparam int unsigned LMAX_A     = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int unsigned LMAX_B     = (IMG_HEIGHT > V_FRONT) ? IMG_HEIGHT : V_FRONT;
  localparam int unsigned LMAX       = (LMAX_A > LMAX_B) ? LMAX_A : LMAX_B;
  localparam int unsigned LW         = (LMAX > 1) ? $clog2(LMAX) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_VSYNC  = 3'd1;
  localparam logic [2:0] S_VBACK  = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_VFRONT = 3'd4;

  logic [2:0]    state, n_state;
  logic [BW-1:0] byte_cnt, n_byte;
  logic [LW-1:0] line_cnt, n_line, last_line;
  logic          start, advance, frame_end, latch;
  logic [1:0]    pat_q;
  logic [11:0]   solid_q;
  logic          n_vsync, n_href;
  logic [7:0]    n_d;
  logic [11:0]   rgb;
  logic [2:0]    bar;
  logic [31:0]   px_x, px_y;

  // State and position register; all outputs registered here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      byte_cnt    <= '0;
      line_cnt    <= '0;
      pclk        <= 1'b0;
      vsync       <= 1'b0;
      href        <= 1'b0;
      d           <= 8'h00;
      frame_done  <= 1'b0;
      frame_count <= 16'h0000;
      busy        <= 1'b0;
      pat_q       <= 2'd0;
      solid_q     <= 12'h000;
    end else begin
      state      <= n_state;
      byte_cnt   <= n_byte;
      line_cnt   <= n_line;
      pclk       <= (state != S_IDLE) ? ~pclk : 1'b0;
      busy       <= (n_state != S_IDLE);
      frame_done <= frame_end;
      if (frame_end) frame_count <= frame_count + 16'd1;
      if (latch) begin
        pat_q   <= pattern;
        solid_q <= solid_rgb;
      end
      if (start || advance) begin
        vsync <= n_vsync;
        href  <= n_href;
        d     <= n_d;
      end
    end
  end

  // Next state / next byte position; advances on each pclk falling edge
  always_comb begin
    n_state   = state;
    n_byte    = byte_cnt;
    n_line    = line_cnt;
    start     = 1'b0;
    advance   = 1'b0;
    frame_end = 1'b0;
    case (state)
      S_VSYNC:  last_line = LW'(VSYNC_LINES - 1);
      S_VBACK:  last_line = LW'(V_BACK - 1);
      S_ACTIVE: last_line = LW'(IMG_HEIGHT - 1);
      default:  last_line = LW'(V_FRONT - 1);
    endcase
    case (state)
      S_IDLE: begin
        if (enable) begin
          n_state = S_VSYNC;
          n_byte  = '0;
          n_line  = '0;
          start   = 1'b1;
        end
      end
      default: begin
        if (pclk) begin
          advance = 1'b1;
          if (byte_cnt == BW'(LINE_BYTES - 1)) begin
            n_byte = '0;
            if (line_cnt == last_line) begin
              n_line = '0;
              case (state)
                S_VSYNC:  n_state = S_VBACK;
                S_VBACK:  n_state = S_ACTIVE;
                S_ACTIVE: n_state = S_VFRONT;
                default: begin
                  frame_end = 1'b1;
                  n_state   = enable ? S_VSYNC : S_IDLE;
                end
              endcase
            end else begin
              n_line = line_cnt + LW'(1);
            end
          end else begin
            n_byte = byte_cnt + BW'(1);
          end
        end
      end
    endcase
    latch = start | (frame_end & enable);
  end

  // Output values for the next byte position, including pattern colour
  always_comb begin
    n_vsync = (n_state == S_VSYNC);
    n_href  = (n_state == S_ACTIVE) && (n_byte < BW'(ACT_BYTES));
    px_x    = 32'(n_byte) >> 1;
    px_y    = 32'(n_line);
    bar     = 3'(px_x / BAR_W);
    rgb     = 12'h000;
    n_d     = 8'h00;
    case (pat_q)
      2'd0: begin
        case (bar)
          3'd0: rgb = 12'hFFF;
          3'd1: rgb = 12'hFF0;
          3'd2: rgb = 12'h0FF;
          3'd3: rgb = 12'h0F0;
          3'd4: rgb = 12'hF0F;
          3'd5: rgb = 12'hF00;
          3'd6: rgb = 12'h00F;
          default: rgb = 12'h000;
        endcase
      end
      2'd1: rgb = (((px_y / STRIPE_H) % 2) == 0) ? 12'hFFF : 12'h000;
      2'd2: rgb = {4'((px_x * 16) / IMG_WIDTH), 4'((px_y * 16) / IMG_HEIGHT), frame_count[3:0]};
      default: rgb = solid_q;
    endcase
    if (n_href) n_d = n_byte[0] ? rgb[7:0] : {4'h0, rgb[11:8]};
  end

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// Self-checking bench for ov7670_stream_gen with small frame geometry.
module tb_ov7670_stream_gen;

  localparam int W = 16, H = 4, HB = 8, VS = 1, VB = 1, VF = 1, SH = 2;
  localparam int LB = 2 * W + HB;
  localparam int FB = (VS + VB + H + VF) * LB;
  localparam int FCLK = 2 * FB;

  logic        clk, rst, enable;
  logic [1:0]  pattern;
  logic [11:0] solid_rgb;
  logic        pclk, vsync, href, frame_done, busy;
  logic [7:0]  d;
  logic [15:0] frame_count;

  int n_checks = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]  pat;
    logic [11:0] solid;
    int          fc;
    int          line;
    int          bidx;
    logic [7:0]  exp_d;
  } vec_t;

  vec_t        vecs[$];
  logic [9:0]  got[FB];
  logic [11:0] bars[8];

  ov7670_stream_gen #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .H_BLANK(HB), .VSYNC_LINES(VS),
    .V_BACK(VB), .V_FRONT(VF), .STRIPE_H(SH)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .pattern(pattern),
    .solid_rgb(solid_rgb), .pclk(pclk), .vsync(vsync), .href(href), .d(d),
    .frame_done(frame_done), .frame_count(frame_count), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Reference: {vsync, href, d} for byte period k of a frame
  function automatic logic [9:0] model_byte(input int k, input logic [1:0] pat,
                                            input logic [11:0] solid, input logic [15:0] fc);
    int lt, b, x, y;
    logic vs, hr;
    logic [11:0] c;
    logic [7:0] dd;
    lt = k / LB;
    b  = k % LB;
    y  = lt - VS - VB;
    vs = (lt < VS);
    hr = (y >= 0) && (y < H) && (b < 2 * W);
    x  = b / 2;
    case (pat)
      2'd0:    c = bars[x / (W / 8)];
      2'd1:    c = (((y / SH) % 2) == 0) ? 12'hFFF : 12'h000;
      2'd2:    c = {4'((x * 16) / W), 4'((y * 16) / H), fc[3:0]};
      default: c = solid;
    endcase
    dd = 8'h00;
    if (hr) dd = ((b % 2) == 0) ? {4'h0, c[11:8]} : c[7:0];
    return {vs, hr, dd};
  endfunction

  // Enable from IDLE; checks the VSYNC-entry cycle
  task automatic start_from_idle(input logic [1:0] pat, input logic [11:0] solid);
    @(negedge clk);
    enable = 1'b1;
    pattern = pat;
    solid_rgb = solid;
    @(negedge clk);
    check("vsync_entry", {busy, vsync, href, pclk}, 4'b1100);
  endtask

  // Captures one frame starting just after its VSYNC-entry edge and checks it
  task automatic capture_frame(input logic [1:0] pat, input logic [11:0] solid, input logic [15:0] fc,
                               input logic [1:0] mid_pat, input logic [11:0] mid_solid, input logic mid_en);
    int k, done_cnt, done_cyc, kk;
    bit timing_ok;
    logic [9:0] e;
    k = 0; done_cnt = 0; done_cyc = -1; timing_ok = 1'b1;
    for (int c = 1; c <= FCLK; c++) begin
      @(negedge clk);
      if (c == 100) begin
        enable = mid_en;
        pattern = mid_pat;
        solid_rgb = mid_solid;
      end
      if (frame_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (c < FCLK && !busy) timing_ok = 1'b0;
      if (pclk && k < FB) begin
        got[k] = {vsync, href, d};
        if (c != 2 * k + 1) timing_ok = 1'b0;
        k++;
      end
    end
    check("byte_periods", k, FB);
    check("pclk_timing", timing_ok, 1);
    for (int i = 0; i < k; i++) begin
      e = model_byte(i, pat, solid, fc);
      if (got[i] !== e) check($sformatf("frame_byte[%0d] pat%0d", i, pat), got[i], e);
      else n_checks++;
    end
    foreach (vecs[j]) begin
      if (vecs[j].pat == pat && (vecs[j].fc < 0 || vecs[j].fc == int'(fc)) &&
          (pat != 2'd3 || vecs[j].solid == solid)) begin
        kk = (VS + VB + vecs[j].line) * LB + vecs[j].bidx;
        check($sformatf("table[%0d]", j), got[kk][7:0], vecs[j].exp_d);
      end
    end
    check("frame_done_once", done_cnt, 1);
    check("frame_done_cycle", done_cyc, FCLK);
    check("frame_count", frame_count, 32'(fc + 16'd1));
    if (mid_en) begin
      check("back_to_back_vsync", {busy, vsync}, 2'b11);
    end else begin
      check("idle_after_frame", {busy, pclk, vsync, href, d}, 0);
      @(negedge clk);
      check("idle_hold", {busy, pclk, vsync, frame_done}, 0);
    end
  endtask

  initial begin
    logic [1:0]  cur_pat, m_pat;
    logic [11:0] cur_solid, m_solid;
    logic        m_en;
    logic [15:0] fc;
    int          bad;

    bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    // pattern 3, solid A5C
    vecs.push_back('{2'd3, 12'hA5C, -1, 0, 0,  8'h0A});
    vecs.push_back('{2'd3, 12'hA5C, -1, 0, 1,  8'h5C});
    vecs.push_back('{2'd3, 12'hA5C, -1, 3, 31, 8'h5C});
    vecs.push_back('{2'd3, 12'hA5C, -1, 1, 32, 8'h00});
    // colour bars
    vecs.push_back('{2'd0, 12'h000, -1, 0, 0,  8'h0F});
    vecs.push_back('{2'd0, 12'h000, -1, 0, 5,  8'hF0});
    vecs.push_back('{2'd0, 12'h000, -1, 1, 9,  8'hFF});
    vecs.push_back('{2'd0, 12'h000, -1, 2, 13, 8'hF0});
    vecs.push_back('{2'd0, 12'h000, -1, 3, 19, 8'h0F});
    vecs.push_back('{2'd0, 12'h000, -1, 0, 21, 8'h00});
    vecs.push_back('{2'd0, 12'h000, -1, 0, 25, 8'h0F});
    vecs.push_back('{2'd0, 12'h000, -1, 0, 30, 8'h00});
    // zebra
    vecs.push_back('{2'd1, 12'h000, -1, 0, 0,  8'h0F});
    vecs.push_back('{2'd1, 12'h000, -1, 1, 7,  8'hFF});
    vecs.push_back('{2'd1, 12'h000, -1, 2, 0,  8'h00});
    vecs.push_back('{2'd1, 12'h000, -1, 3, 5,  8'h00});
    // gradient
    vecs.push_back('{2'd2, 12'h000, 0, 3, 14, 8'h07});
    vecs.push_back('{2'd2, 12'h000, 0, 3, 15, 8'hC0});
    vecs.push_back('{2'd2, 12'h000, 1, 0, 31, 8'h01});
    vecs.push_back('{2'd2, 12'h000, 2, 1, 30, 8'h0F});
    vecs.push_back('{2'd2, 12'h000, 2, 2, 9,  8'h82});

    rst = 1'b1; enable = 1'b0; pattern = 2'd0; solid_rgb = 12'h000;
    repeat (3) @(negedge clk);
    check("reset_state", {pclk, vsync, href, d, frame_done, busy, frame_count}, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_no_enable", {busy, pclk, vsync}, 0);

    // solid, then bars, then zebra with enable dropped mid-frame
    start_from_idle(2'd3, 12'hA5C);
    capture_frame(2'd3, 12'hA5C, 16'd0, 2'd0, 12'h123, 1'b1);
    capture_frame(2'd0, 12'h123, 16'd1, 2'd1, 12'h777, 1'b1);
    capture_frame(2'd1, 12'h777, 16'd2, 2'd2, 12'h000, 1'b0);
    repeat (6) @(negedge clk);
    check("idle_stays", {busy, pclk, frame_done}, 0);
    start_from_idle(2'd3, 12'h5A5);
    capture_frame(2'd3, 12'h5A5, 16'd3, 2'd3, 12'h5A5, 1'b0);

    // asynchronous reset in the middle of an active line
    start_from_idle(2'd0, 12'h000);
    repeat (171) @(negedge clk);
    check("pre_reset_href", href, 1);
    #2 rst = 1'b1;
    #1 check("async_reset_outputs", {pclk, vsync, href, d, frame_done, busy, frame_count}, 0);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (frame_done || busy) bad++;
    end
    enable = 1'b0;
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (frame_done || busy || pclk) bad++;
    end
    check("reset_no_frame_done", bad, 0);

    // three back-to-back gradient frames
    start_from_idle(2'd2, 12'h000);
    capture_frame(2'd2, 12'h000, 16'd0, 2'd2, 12'h000, 1'b1);
    capture_frame(2'd2, 12'h000, 16'd1, 2'd2, 12'h000, 1'b1);
    capture_frame(2'd2, 12'h000, 16'd2, 2'd0, 12'h000, 1'b0);
    check("three_frames", frame_count, 3);

    // randomized patterns, colours and enable drops
    fc = 16'd3;
    cur_pat = 2'($urandom_range(0, 3));
    cur_solid = 12'($urandom);
    start_from_idle(cur_pat, cur_solid);
    for (int r = 0; r < 5; r++) begin
      m_pat = 2'($urandom_range(0, 3));
      m_solid = 12'($urandom);
      m_en = ($urandom_range(0, 2) != 0) || (r == 4);
      if (r == 4) m_en = 1'b0;
      capture_frame(cur_pat, cur_solid, fc, m_pat, m_solid, m_en);
      fc = fc + 16'd1;
      if (m_en) begin
        cur_pat = m_pat;
        cur_solid = m_solid;
      end else if (r < 4) begin
        cur_pat = 2'($urandom_range(0, 3));
        cur_solid = 12'($urandom);
        start_from_idle(cur_pat, cur_solid);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
